// File: rtl/sram_pkg.sv
// Constants shared by the SRAM controller and the SRAM responder.
package sram_pkg;
  localparam int SRAM_DATA_W = 8;
  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DEPTH  = 1 << SRAM_ADDR_W;

  // Active-low strobe levels on the SRAM interface.
  localparam logic ENA    = 1'b0;
  localparam logic DISENA = 1'b1;

  // Responder state encoding.
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: RD_LAT stages of {valid, data}. Data in a stage only
// changes when a valid word moves into it, so the last stage holds the most
// recent completed read. Flush drops every in-flight word without touching data.
module sram_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic              vld_q [RD_LAT];
  logic              vld_d [RD_LAT];
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic [DATA_W-1:0] dat_d [RD_LAT];

  // Next-stage values: shift valid words forward, hold data otherwise.
  always_comb begin
    vld_d[0] = in_valid && !flush;
    dat_d[0] = (in_valid && !flush) ? in_data : dat_q[0];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1] && !flush;
      dat_d[i] = (vld_q[i-1] && !flush) ? dat_q[i-1] : dat_q[i];
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RD_LAT; i++) begin
      if (!reset_n) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end else begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign out_valid = vld_q[RD_LAT-1];
  assign out_data  = dat_q[RD_LAT-1];
endmodule

// File: rtl/sram_resp.sv
// Synchronous SRAM responder: clears its array after reset or on request,
// then serves active-low strobe reads/writes with RD_LAT cycles of read latency.
module sram_resp import sram_pkg::*; #(
  parameter int                 DATA_W  = SRAM_DATA_W,
  parameter int                 ADDR_W  = SRAM_ADDR_W,
  parameter int                 RD_LAT  = 1,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_cen,
  input  logic              s_wen,
  input  logic              s_oen,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_ddata,
  output logic [DATA_W-1:0] s_qdata,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       rd_cnt,
  output logic              conflict
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              launch_q, launch_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic              conflict_q, conflict_d;
  logic              flush;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // FSM, array write port, read launch and counter next-state logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    launch_d   = 1'b0;
    rdata_d    = rdata_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    conflict_d = conflict_q;
    flush      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = s_addr;
    mem_wdata  = s_ddata;
    if (state_q == ST_CLEAR) begin
      // The pointer's extra MSB marks that the last word has been written.
      mem_we    = 1'b1;
      mem_waddr = ptr_q[ADDR_W-1:0];
      mem_wdata = CLR_VAL;
      ptr_d     = ptr_q + 1'b1;
      if (clr_req) begin
        ptr_d = '0;
      end else if (ptr_d[ADDR_W]) begin
        state_d = ST_RUN;
      end
    end else if (clr_req) begin
      state_d    = ST_CLEAR;
      ptr_d      = '0;
      flush      = 1'b1;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      conflict_d = 1'b0;
    end else if (s_cen == ENA) begin
      if (s_wen == ENA) begin
        // Write wins over a simultaneous read strobe; that case is flagged.
        mem_we = 1'b1;
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 32'd1;
        if (s_oen == ENA) conflict_d = 1'b1;
      end else if (s_wen == DISENA && s_oen == ENA) begin
        launch_d = 1'b1;
        rdata_d  = mem_q[s_addr];
        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      launch_q   <= 1'b0;
      rdata_q    <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      launch_q   <= launch_d;
      rdata_q    <= rdata_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      conflict_q <= conflict_d;
    end
  end

  // Storage array; no reset, contents are established by the clear walk.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (launch_q),
    .in_data   (rdata_q),
    .out_valid (rd_valid),
    .out_data  (s_qdata)
  );

  assign busy     = (state_q == ST_CLEAR);
  assign wr_cnt   = wr_cnt_q;
  assign rd_cnt   = rd_cnt_q;
  assign conflict = conflict_q;
endmodule

// File: doc/sram_resp.md
# sram_resp

Synthesizable synchronous SRAM responder that answers the active-low SRAM strobe interface (`s_cen`/`s_wen`/`s_oen`/`s_addr`/`s_ddata` → `s_qdata`) driven by the SRAM controller. It stands in for the external SRAM in simulation and on-FPGA self-test. It clears its array after reset, services writes and reads with a configurable read latency, and exposes access counters and a protocol-conflict flag to the bus status registers.

## Interface
- `DATA_W`, 8: data width.
- `ADDR_W`, 10: address width; depth = 2^ADDR_W.
- `RD_LAT`, 1: read latency in cycles; legal range 1..4.
- `CLR_VAL`, 0: value written to every word during clear.

Ports:
- `clk`  in  1  block clock; the system drives the controller's `s_clk` from the same net.
- `reset_n`  in  1  reset, synchronous, active-low.
- `s_cen`  in  1  chip enable, active-low.
- `s_wen`  in  1  write enable, active-low.
- `s_oen`  in  1  output (read) enable, active-low.
- `s_addr`  in  ADDR_W  access address.
- `s_ddata`  in  DATA_W  write data.
- `s_qdata`  out  DATA_W  read data.
- `rd_valid`  out  1  one-cycle pulse when `s_qdata` is updated by a read.
- `clr_req`  in  1  pulse: restart the clear sequence.
- `busy`  out  1  clear in progress; accesses are ignored.
- `wr_cnt`  out  32  accepted writes, saturating.
- `rd_cnt`  out  32  accepted reads, saturating.
- `conflict`  out  1  sticky: `s_wen` and `s_oen` were both low with `s_cen` low.

## Operation
- Two-state FSM: CLEAR and RUN. Reset enters CLEAR.
- CLEAR:
  - An internal pointer walks addresses 0..2^ADDR_W-1, writing `CLR_VAL` at one address per cycle.
  - `busy` is 1 throughout. The strobe inputs are ignored and not counted.
  - After the last address is written, the FSM moves to RUN.
- RUN, `s_cen`=1: no operation.
- RUN, `s_cen`=0 and `s_wen`=0:
  - `mem[s_addr]` ← `s_ddata`; `wr_cnt` increments.
  - If `s_oen`=0 in the same cycle, `conflict` sets. The write still occurs and no read is launched.
- RUN, `s_cen`=0, `s_wen`=1, `s_oen`=0:
  - Read launched: `mem[s_addr]` is sampled and `rd_cnt` increments.
  - Back-to-back reads, one per cycle, are fully supported.
- RUN, `s_cen`=0, `s_wen`=1, `s_oen`=1: idle; nothing counted.
- `s_qdata` holds its last read value whenever no read completes.
- `clr_req` in RUN:
  - Enters CLEAR and clears `wr_cnt`, `rd_cnt`, `conflict` and the read pipeline.
  - `s_qdata` is not cleared. Any access in the same cycle is dropped.
- `clr_req` in CLEAR: restarts the pointer at 0.
- Counters saturate at 0xFFFF_FFFF and never wrap.
- Address arithmetic: the clear pointer is ADDR_W+1 bits wide; its MSB terminates CLEAR. `s_addr` is used unmodified. There is no out-of-range case.

## Timing
- Reset values:
  - `s_qdata`=0, `rd_valid`=0, `busy`=1, `wr_cnt`=0, `rd_cnt`=0, `conflict`=0.
  - Read pipeline empty; state CLEAR; pointer 0.
- Clear duration is 2^ADDR_W cycles. `busy` first reads 0 in cycle 2^ADDR_W after reset release, and accesses are accepted from that cycle.
- Read latency:
  - A read launched at edge N updates `s_qdata` at edge N+RD_LAT.
  - `rd_valid` is high for the cycle following that edge.
- Write-to-read hazards:
  - A write at edge N followed by a read launched at edge N+1 to the same address returns the new data.
  - A read launched at edge N samples memory before any write at N. This case cannot occur on the interface, because write takes priority.
- Reads in flight when CLEAR is entered (by reset or `clr_req`) are discarded; `rd_valid` does not pulse for them.
- Reset asserted mid-clear or mid-read: all state returns to the reset values listed above at the next edge.

## Structure
- Shared package `sram_pkg`:
  - `DATA_W`, `ADDR_W`, depth.
  - Strobe polarity constants: `ENA`=0, `DISENA`=1, used by both controller and responder.
  - Responder state encoding.
- Sub-module `sram_rd_pipe`: RD_LAT-deep shift register of {valid, data}, with a synchronous flush input. The top level holds the FSM, array, counters and conflict flag.

## Test plan
- Clear after reset:
  - Release reset with `RD_LAT`=1 and `CLR_VAL`=0xA5.
  - `busy` falls after 1024 cycles.
  - Reading addresses 0, 511 and 1023 returns 0xA5 each time; `rd_cnt`=3.
- Write then read:
  - Write 0x3C to 0x010, then read 0x010 in the next cycle.
  - `s_qdata`=0x3C one cycle after the read launch; `wr_cnt`=1; `rd_valid` pulses once.
- Latency sweep:
  - For `RD_LAT`=1..4, issue back-to-back reads of 0x000..0x007 prewritten with 0x00..0x07.
  - Data appears in order, exactly `RD_LAT` cycles after each launch, one word per cycle.
- Conflict:
  - Drive `s_cen`=0, `s_wen`=0, `s_oen`=0, address 0x020, data 0x55.
  - `conflict`=1 and stays set; `mem[0x020]`=0x55; no `rd_valid`; `rd_cnt` unchanged.
- Mid-flight clear:
  - With `RD_LAT`=3, launch a read, then pulse `clr_req` the next cycle.
  - No `rd_valid` occurs; `busy`=1 for 1024 cycles; counters read 0.
- Saturation:
  - Force `wr_cnt`=0xFFFF_FFFE, then issue three writes.
  - `wr_cnt` reads 0xFFFF_FFFF.
